// File: rtl/lib_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
// Helpers work on vectors up to ARB_MAX_N bits wide. Callers zero-extend into them and truncate back out.
package lib_arb_pkg;

  localparam int ARB_MAX_N = 64;
  localparam int ARB_IDX_W = $clog2(ARB_MAX_N);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // One-hot rotate left by one within the low n bits. Bit n-1 wraps to bit 0.
  function automatic logic [ARB_MAX_N-1:0] rotl1(input logic [ARB_MAX_N-1:0] v,
                                                 input int n);
    logic [ARB_MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (i == 0) r[0] = v[n-1];
      else if (i < n) r[i] = v[i-1];
    end
    return r;
  endfunction

  // Binary index of a one-hot vector. The result is 0 for an all-zero input.
  function automatic logic [ARB_IDX_W-1:0] onehot2idx(input logic [ARB_MAX_N-1:0] v);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (v[i]) idx = idx | ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lib_fppe.sv
// Fast programmable priority encoder: grants the first requester at or after
// the one-hot priority position, searching upward with wrap-around.
module LIB_FPPE #(
  parameter int N   = 16,
  parameter int LAH = 4
) (
  input  logic [N-1:0] i_request,
  input  logic [N-1:0] i_priority,
  output logic [N-1:0] o_grant,
  output logic         o_anyGnt
);

  localparam int GS = (LAH == 0) ? N : LAH;
  localparam int NG = (2 * N) / GS;

  if (N < 2) begin : g_bad_n
    $error("LIB_FPPE: N must be at least 2");
  end
  if (LAH > 0 && (N % LAH) != 0) begin : g_bad_lah
    $error("LIB_FPPE: N must be a multiple of LAH");
  end

  logic [2*N-1:0] gnt2;
  logic           tok;
  logic           t;
  logic           l;
  logic           none;
  int             j;
  int             b;

  // The search token runs over two copies of the request vector to cover the wrap-around.
  // Each group's carry-out skips the group when it holds no request.
  // l is the group's own carry-out, computed with no incoming token.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latch).
    gnt2 = '0;
    tok  = 1'b0;
    t    = 1'b0;
    l    = 1'b0;
    none = 1'b1;
    j    = 0;
    b    = 0;
    for (int g = 0; g < NG; g++) begin
      t    = tok;
      l    = 1'b0;
      none = 1'b1;
      for (int k = 0; k < GS; k++) begin
        j = g * GS + k;
        b = j % N;
        if (j < N) begin
          t = t | i_priority[b];
          l = l | i_priority[b];
        end
        gnt2[j] = t & i_request[b];
        t       = t & ~i_request[b];
        l       = l & ~i_request[b];
        none    = none & ~i_request[b];
      end
      tok = (LAH == 0) ? t : ((tok & none) | l);
    end
    o_grant = gnt2[N-1:0] | gnt2[2*N-1:N];
  end

  assign o_anyGnt = |o_grant;

endmodule

// File: rtl/lib_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter. Holds one grant from the head flit to the tail flit.
// The grant then rotates, with the current owner taking the lowest priority.
module lib_pkt_rr_arbiter
  import lib_arb_pkg::*;
#(
  parameter int N   = 16,
  parameter int LAH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         i_request,
  input  logic [N-1:0]         i_tail,
  input  logic                 i_ready,
  output logic [N-1:0]         o_grant,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_sel,
  output logic [N-1:0]         o_priority
);

  localparam int SW = $clog2(N);

  if (N > ARB_MAX_N) begin : g_bad_n
    $error("lib_pkt_rr_arbiter: N exceeds ARB_MAX_N");
  end

  arb_state_e           state_q, state_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [N-1:0]         ptr_q, ptr_d;
  logic                 valid_q;
  logic [SW-1:0]        sel_q;
  logic [N-1:0]         rot_gnt;
  logic [N-1:0]         fppe_req, fppe_pri, fppe_gnt;
  logic                 fppe_any;
  logic                 xfer, tail_xfer, withdrawn, release_gnt;
  logic [ARB_IDX_W-1:0] sel_full;

  assign rot_gnt   = N'(rotl1(ARB_MAX_N'(grant_q), N));
  assign xfer      = valid_q & (|(grant_q & i_request)) & i_ready;
  assign tail_xfer = xfer & (|(grant_q & i_tail));
  // A withdrawn request releases the grant regardless of i_ready, so it cannot deadlock the port.
  assign withdrawn   = (state_q == HOLD) & ~(|(grant_q & i_request));
  assign release_gnt = tail_xfer | withdrawn;

  // While holding, the encoder looks ahead for the next packet owner.
  // The current owner is excluded from that search.
  assign fppe_req = (state_q == HOLD) ? (i_request & ~grant_q) : i_request;
  assign fppe_pri = (state_q == HOLD) ? rot_gnt : ptr_q;

  LIB_FPPE #(
    .N   (N),
    .LAH (LAH)
  ) u_fppe (
    .i_request  (fppe_req),
    .i_priority (fppe_pri),
    .o_grant    (fppe_gnt),
    .o_anyGnt   (fppe_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (fppe_any) begin
          grant_d = fppe_gnt;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (release_gnt) begin
          ptr_d = rot_gnt;
          if (fppe_any) begin
            grant_d = fppe_gnt;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign sel_full = onehot2idx(ARB_MAX_N'(grant_d));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register updates from the same pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= N'(1);
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      valid_q <= |grant_d;
      sel_q   <= sel_full[SW-1:0];
    end
  end

  assign o_grant    = grant_q;
  assign o_valid    = valid_q;
  assign o_sel      = sel_q;
  assign o_priority = ptr_q;

endmodule

// File: tb/tb_lib_pkt_rr_arbiter.sv
// Scoreboard bench for lib_pkt_rr_arbiter at N=4, LAH=2 using directed, hand-computed vectors.
module tb_lib_pkt_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] i_request;
  logic [3:0] i_tail;
  logic       i_ready;
  logic [3:0] o_grant;
  logic       o_valid;
  logic [1:0] o_sel;
  logic [3:0] o_priority;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic [3:0] p;
  } exp_t;

  exp_t  exp_q[$];
  string cur_tag;
  int    n_checks;
  int    n_errors;

  lib_pkt_rr_arbiter #(
    .N   (4),
    .LAH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_request  (i_request),
    .i_tail     (i_tail),
    .i_ready    (i_ready),
    .o_grant    (o_grant),
    .o_valid    (o_valid),
    .o_sel      (o_sel),
    .o_priority (o_priority)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] tail,
                       input logic rdy);
    reset     = rst;
    i_request = req;
    i_tail    = tail;
    i_ready   = rdy;
  endtask

  // Expected outputs for the cycle that follows the next rising edge.
  task automatic tick(input logic [3:0] g, input logic [3:0] p);
    @(posedge clk);
    #1;
    exp_q.push_back('{cur_tag, g, p});
  endtask

  // Monitor: samples mid-cycle and retires one scoreboard entry per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".grant"}, 32'(o_grant), 32'(e.g));
      check({e.tag, ".valid"}, 32'(o_valid), 32'(|e.g));
      check({e.tag, ".sel"}, 32'(o_sel), 32'(idx_of(e.g)));
      check({e.tag, ".prio"}, 32'(o_priority), 32'(e.p));
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(o_valid && ((o_grant & i_request) == 4'b0000)))
        else $error("protocol violation: request withdrawn while granted");
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    cur_tag  = "reset";
    drive(1'b1, 4'b0000, 4'b0000, 1'b1);
    tick(4'b0000, 4'b0001);

    // Two requesters with single-flit packets alternate with no bubble.
    cur_tag = "alternate";
    drive(1'b0, 4'b1010, 4'b1111, 1'b1);
    tick(4'b0010, 4'b0001);
    tick(4'b1000, 4'b0100);
    tick(4'b0010, 4'b0001);
    tick(4'b1000, 4'b0100);
    drive(1'b0, 4'b1000, 4'b1111, 1'b1);
    tick(4'b0000, 4'b0001);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    tick(4'b0000, 4'b0001);

    // A 3-flit packet from requester 0 holds the grant while requester 2 waits.
    cur_tag = "hold";
    drive(1'b1, 4'b0000, 4'b0000, 1'b1);
    tick(4'b0000, 4'b0001);
    drive(1'b0, 4'b0101, 4'b0000, 1'b1);
    tick(4'b0001, 4'b0001);
    tick(4'b0001, 4'b0001);
    tick(4'b0001, 4'b0001);
    drive(1'b0, 4'b0101, 4'b0001, 1'b1);
    tick(4'b0100, 4'b0010);
    drive(1'b0, 4'b0101, 4'b0100, 1'b1);
    tick(4'b0001, 4'b1000);
    drive(1'b0, 4'b0001, 4'b0001, 1'b1);
    tick(4'b0000, 4'b0010);

    // Backpressure freezes the grant and pointer. The tail goes through once i_ready returns.
    cur_tag = "backpressure";
    drive(1'b1, 4'b0000, 4'b0000, 1'b1);
    tick(4'b0000, 4'b0001);
    drive(1'b0, 4'b0100, 4'b0000, 1'b1);
    tick(4'b0100, 4'b0001);
    drive(1'b0, 4'b0100, 4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) tick(4'b0100, 4'b0001);
    drive(1'b0, 4'b0100, 4'b0100, 1'b1);
    tick(4'b0000, 4'b1000);

    // The pointer sits at bit 3, so the search wraps to requester 0.
    cur_tag = "wrap";
    drive(1'b0, 4'b0011, 4'b0000, 1'b1);
    tick(4'b0001, 4'b1000);
    drive(1'b0, 4'b0011, 4'b0001, 1'b1);
    tick(4'b0010, 4'b0010);
    drive(1'b0, 4'b0010, 4'b0010, 1'b1);
    tick(4'b0000, 4'b0100);

    // A lone requester gets one idle bubble between its packets.
    cur_tag = "single";
    drive(1'b1, 4'b0000, 4'b0000, 1'b1);
    tick(4'b0000, 4'b0001);
    drive(1'b0, 4'b0100, 4'b1111, 1'b1);
    tick(4'b0100, 4'b0001);
    tick(4'b0000, 4'b1000);
    tick(4'b0100, 4'b1000);
    tick(4'b0000, 4'b1000);

    // Reset in the middle of a packet wins over the held grant.
    cur_tag = "midreset";
    drive(1'b0, 4'b0100, 4'b0000, 1'b1);
    tick(4'b0100, 4'b1000);
    tick(4'b0100, 4'b1000);
    drive(1'b1, 4'b0100, 4'b0000, 1'b1);
    tick(4'b0000, 4'b0001);
    drive(1'b0, 4'b1111, 4'b0000, 1'b1);
    tick(4'b0001, 4'b0001);
    drive(1'b0, 4'b0001, 4'b0001, 1'b1);
    tick(4'b0000, 4'b0010);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
